pixel_mem_arbiter: RTL and testbench

Shares the single port of the 160x120, 3-bit-colour pixel RAM between the four star-finding engines: pixel scanner, row/column mapper, square drawer and star cleaner. It performs request/grant arbitration with bounded bursts, translates (x, y) to a linear address, range-checks coordinates, and routes 1-cycle-latency read data back to the issuing requester. It sits between the top-level control FSM's engines and the pixel RAM.

---
 rtl/pixel_mem_pkg.sv | 29 ++
 rtl/vga_address_translator.sv | 19 +
 rtl/pixel_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pixel_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_pkg.sv
// Shared definitions for the pixel RAM arbiter: screen geometry, bus widths,
// requester indices, the arbiter state type and a coordinate range helper.
package pixel_mem_pkg;

   localparam int MAX_X  = 160;
   localparam int MAX_Y  = 120;

   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int ADDR_W = 15;
   localparam int COL_W  = 3;

   localparam int REQ_SCAN  = 0;
   localparam int REQ_MAP   = 1;
   localparam int REQ_DRAW  = 2;
   localparam int REQ_CLEAN = 3;

   typedef enum logic {
      ARB_IDLE,
      ARB_OWNED
   } arb_state_t;

   // True when (x, y) lies on the 160x120 screen.
   function automatic logic coord_in_range(input logic [X_W-1:0] cx,
                                           input logic [Y_W-1:0] cy);
      return (cx < X_W'(MAX_X)) && (cy < Y_W'(MAX_Y));
   endfunction

endpackage

// File: rtl/vga_address_translator.sv
// Converts a 160x120 screen coordinate into a linear pixel RAM address,
// y*160 + x, built from shifts.  The sum is formed directly at 15 bits,
// which wraps identically to a 16-bit sum truncated to 15 bits.
module vga_address_translator
   import pixel_mem_pkg::*;
(
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] mem_address
);

   logic [ADDR_W-1:0] x_ext;
   logic [ADDR_W-1:0] y_ext;

   assign x_ext       = ADDR_W'(x);
   assign y_ext       = ADDR_W'(y);
   assign mem_address = (y_ext << 7) + (y_ext << 5) + x_ext;

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Shares the single pixel RAM port between the scan, map, draw and clean
// engines.  Grants are bounded bursts with a one-cycle bubble between owners,
// reads return one cycle after issue to the issuing requester, and
// off-screen accesses are flagged and never written.
// Build option: define PIXEL_ARB_RR_EN for round-robin arbitration; without
// it the lowest requester index wins.
module pixel_mem_arbiter
   import pixel_mem_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 16
)(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       we,
   input  logic [X_W*N_REQ-1:0]   x,
   input  logic [Y_W*N_REQ-1:0]   y,
   input  logic [COL_W*N_REQ-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       rvalid,
   output logic [COL_W-1:0]       rdata,
   output logic                   oob_err,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_wren,
   output logic [COL_W-1:0]       mem_wdata,
   input  logic [COL_W-1:0]       mem_rdata
);

   localparam int         IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

   arb_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [7:0]       burst_cnt;
   logic             rd_oob;
   logic [IDX_W-1:0] winner;

   logic [X_W-1:0]   own_x;
   logic [Y_W-1:0]   own_y;
   logic             in_range;
   logic             issue;
   logic             others_waiting;
   logic [7:0]       cnt_next;
   logic [N_REQ-1:0] own_mask;

`ifdef PIXEL_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr;

   // Round-robin: first requester found searching upward from the pointer.
   function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                    input logic [IDX_W-1:0] start);
      logic [IDX_W-1:0] win;
      logic             found;
      int               k;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(start) + i) % N_REQ;
         if (!found && r[k]) begin
            win   = IDX_W'(k);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   // Candidate winner for the next arbitration edge.
   always_comb begin
      winner = pick_winner(req, rr_ptr);
   end
`else
   // Fixed priority: the lowest requesting index wins.
   function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r);
      logic [IDX_W-1:0] win;
      win = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (r[i]) win = IDX_W'(i);
      end
      return win;
   endfunction

   // Candidate winner for the next arbitration edge.
   always_comb begin
      winner = pick_winner(req);
   end
`endif

   // Owner's request fields, access qualification and burst bookkeeping.
   always_comb begin
      own_x          = x[int'(owner)*X_W +: X_W];
      own_y          = y[int'(owner)*Y_W +: Y_W];
      mem_wdata      = wdata[int'(owner)*COL_W +: COL_W];
      in_range       = coord_in_range(own_x, own_y);
      issue          = (state == ARB_OWNED) && gnt[owner] && req[owner];
      mem_wren       = issue && we[owner] && in_range;
      own_mask       = '0;
      own_mask[owner] = 1'b1;
      others_waiting = |(req & ~own_mask);
      cnt_next       = (burst_cnt >= BURST_LIM) ? BURST_LIM : burst_cnt + 8'd1;
   end

   vga_address_translator u_addr (
      .x           (own_x),
      .y           (own_y),
      .mem_address (mem_addr)
   );

   // Read data is only meaningful while rvalid is up; off-screen reads return 0.
   assign rdata = ((|rvalid) && !rd_oob) ? mem_rdata : '0;

   // Arbiter FSM: grant, burst limiting, release, and read/error return flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ARB_IDLE;
         owner     <= '0;
         gnt       <= '0;
         burst_cnt <= '0;
         rvalid    <= '0;
         rd_oob    <= 1'b0;
         oob_err   <= 1'b0;
`ifdef PIXEL_ARB_RR_EN
         rr_ptr    <= '0;
`endif
      end else begin
         rvalid  <= '0;
         oob_err <= 1'b0;
         if (issue) begin
            oob_err <= !in_range;
            if (!we[owner]) begin
               rvalid[owner] <= 1'b1;
               rd_oob        <= !in_range;
            end
         end

         case (state)
            ARB_IDLE: begin
               if (|req) begin
                  gnt         <= '0;
                  gnt[winner] <= 1'b1;
                  owner       <= winner;
                  burst_cnt   <= '0;
                  state       <= ARB_OWNED;
`ifdef PIXEL_ARB_RR_EN
                  rr_ptr      <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
`endif
               end
            end
            ARB_OWNED: begin
               if (!req[owner]) begin
                  gnt   <= '0;
                  state <= ARB_IDLE;
               end else begin
                  burst_cnt <= cnt_next;
                  if ((cnt_next == BURST_LIM) && others_waiting) begin
                     gnt   <= '0;
                     state <= ARB_IDLE;
                  end
               end
            end
            default: begin
               gnt   <= '0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed self-checking bench for pixel_mem_arbiter with a behavioural
// 1-cycle-latency pixel RAM preloaded with ((addr % 7) + 1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pixel_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [31:0] x;
   logic [27:0] y;
   logic [11:0] wdata;
   logic [3:0]  gnt;
   logic [3:0]  rvalid;
   logic [2:0]  rdata;
   logic        oob_err;
   logic [14:0] mem_addr;
   logic        mem_wren;
   logic [2:0]  mem_wdata;
   logic [2:0]  mem_rdata;

   logic [2:0]  ram [0:32767];
   logic        loaded = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pixel_mem_arbiter #(.N_REQ(4), .MAX_BURST(16)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .we        (we),
      .x         (x),
      .y         (y),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .oob_err   (oob_err),
      .mem_addr  (mem_addr),
      .mem_wren  (mem_wren),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Pixel RAM model: preload on the first edge, then synchronous write and read.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 3'((i % 7) + 1);
         loaded <= 1'b1;
      end else if (mem_wren) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   task automatic set_req(input int idx, input logic w, input logic [7:0] xv,
                          input logic [6:0] yv, input logic [2:0] wd);
      req[idx]            = 1'b1;
      we[idx]             = w;
      x[idx*8 +: 8]       = xv;
      y[idx*7 +: 7]       = yv;
      wdata[idx*3 +: 3]   = wd;
   endtask

   task automatic go_idle();
      req = '0;
      we  = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      req    = 4'b0001;
      we     = 4'b0001;
      x      = '0;
      y      = '0;
      wdata  = 12'hfff;
      repeat (3) @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected %b", rvalid, 4'b0000); end
      checks++; if (rdata !== 3'd0) begin errors++; $display("[TB] FAIL reset_rdata: got %0d expected 0", rdata); end
      checks++; if (oob_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_oob: got %b expected 0", oob_err); end
      checks++; if (mem_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren: got %b expected 0", mem_wren); end
      req = '0;
      we  = '0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read_scan();
      @(negedge clk);
      set_req(0, 1'b0, 8'd5, 7'd2, 3'd0);
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL scan_gnt: got %b expected %b", gnt, 4'b0001); end
      checks++; if (mem_addr !== 15'd325) begin errors++; $display("[TB] FAIL scan_addr: got %0d expected 325", mem_addr); end
      checks++; if (mem_wren !== 1'b0) begin errors++; $display("[TB] FAIL scan_wren: got %b expected 0", mem_wren); end
      @(negedge clk);
      checks++; if (rvalid !== 4'b0001) begin errors++; $display("[TB] FAIL scan_rvalid: got %b expected %b", rvalid, 4'b0001); end
      checks++; if (rdata !== 3'd4) begin errors++; $display("[TB] FAIL scan_rdata: got %0d expected 4", rdata); end
      req = '0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL scan_release: got %b expected %b", gnt, 4'b0000); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL scan_single_rvalid: got %b expected %b", rvalid, 4'b0000); end
      go_idle();
   endtask

   task automatic test_contention();
      @(negedge clk);
      set_req(1, 1'b0, 8'd10, 7'd1, 3'd0);
      set_req(3, 1'b0, 8'd0, 7'd3, 3'd0);
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL cont_first_gnt: got %b expected %b", gnt, 4'b0010); end
      checks++; if (mem_addr !== 15'd170) begin errors++; $display("[TB] FAIL cont_map_addr: got %0d expected 170", mem_addr); end
      req[1] = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL cont_bubble: got %b expected %b", gnt, 4'b0000); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL cont_no_read: got %b expected %b", rvalid, 4'b0000); end
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL cont_second_gnt: got %b expected %b", gnt, 4'b1000); end
      checks++; if (mem_addr !== 15'd480) begin errors++; $display("[TB] FAIL cont_clean_addr: got %0d expected 480", mem_addr); end
      go_idle();
   endtask

   task automatic test_burst_limit();
      int   hi;
      logic dropped;
      logic [3:0] exp_next;
      hi      = 0;
      dropped = 1'b0;
      @(negedge clk);
      set_req(0, 1'b0, 8'd1, 7'd0, 3'd0);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (gnt[0]) hi++;
         else if (hi > 0) begin
            dropped = 1'b1;
            break;
         end
         if (cyc == 3) set_req(2, 1'b0, 8'd2, 7'd0, 3'd0);
      end
      checks++; if (dropped !== 1'b1) begin errors++; $display("[TB] FAIL burst_drop_timeout: got %b expected 1", dropped); end
      checks++; if (hi != 16) begin errors++; $display("[TB] FAIL burst_len: got %0d expected 16", hi); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL burst_bubble: got %b expected %b", gnt, 4'b0000); end
      checks++; if (rvalid !== 4'b0001) begin errors++; $display("[TB] FAIL burst_last_rvalid: got %b expected %b", rvalid, 4'b0001); end
`ifdef PIXEL_ARB_RR_EN
      exp_next = 4'b0100;
`else
      exp_next = 4'b0001;
`endif
      @(negedge clk);
      checks++; if (gnt !== exp_next) begin errors++; $display("[TB] FAIL burst_next_owner: got %b expected %b", gnt, exp_next); end
      go_idle();
   endtask

   task automatic test_no_preempt();
      int hi;
      hi = 0;
      @(negedge clk);
      set_req(3, 1'b0, 8'd0, 7'd0, 3'd0);
      repeat (30) begin
         @(negedge clk);
         if (gnt === 4'b1000) hi++;
      end
      checks++; if (hi != 30) begin errors++; $display("[TB] FAIL solo_hold: got %0d expected 30", hi); end
      go_idle();
   endtask

   task automatic test_out_of_range();
      int pulses;
      int wren_seen;
      pulses    = 0;
      wren_seen = 0;
      @(negedge clk);
      set_req(0, 1'b1, 8'd160, 7'd0, 3'b111);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (oob_err === 1'b1) pulses++;
         if (mem_wren === 1'b1) wren_seen++;
         if (i == 1) begin
            req = '0;
            we  = '0;
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL oob_write_pulses: got %0d expected 1", pulses); end
      checks++; if (wren_seen != 0) begin errors++; $display("[TB] FAIL oob_write_wren: got %0d expected 0", wren_seen); end
      @(negedge clk);
      set_req(0, 1'b0, 8'd0, 7'd120, 3'd0);
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL oob_read_gnt: got %b expected %b", gnt, 4'b0001); end
      @(negedge clk);
      checks++; if (rvalid !== 4'b0001) begin errors++; $display("[TB] FAIL oob_read_rvalid: got %b expected %b", rvalid, 4'b0001); end
      checks++; if (rdata !== 3'd0) begin errors++; $display("[TB] FAIL oob_read_rdata: got %0d expected 0", rdata); end
      checks++; if (oob_err !== 1'b1) begin errors++; $display("[TB] FAIL oob_read_err: got %b expected 1", oob_err); end
      go_idle();
   endtask

   task automatic test_write_read();
      @(negedge clk);
      set_req(2, 1'b1, 8'd159, 7'd119, 3'b101);
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL wr_gnt: got %b expected %b", gnt, 4'b0100); end
      checks++; if (mem_addr !== 15'd19199) begin errors++; $display("[TB] FAIL wr_addr: got %0d expected 19199", mem_addr); end
      checks++; if (mem_wren !== 1'b1) begin errors++; $display("[TB] FAIL wr_wren: got %b expected 1", mem_wren); end
      checks++; if (mem_wdata !== 3'b101) begin errors++; $display("[TB] FAIL wr_wdata: got %b expected 101", mem_wdata); end
      @(negedge clk);
      we[2] = 1'b0;
      @(negedge clk);
      checks++; if (rvalid !== 4'b0100) begin errors++; $display("[TB] FAIL rd_rvalid: got %b expected %b", rvalid, 4'b0100); end
      checks++; if (rdata !== 3'b101) begin errors++; $display("[TB] FAIL rd_rdata: got %b expected 101", rdata); end
      go_idle();
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      set_req(0, 1'b0, 8'd5, 7'd2, 3'd0);
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rstmid_gnt_before: got %b expected %b", gnt, 4'b0001); end
      resetn = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_gnt_now: got %b expected %b", gnt, 4'b0000); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_rvalid_now: got %b expected %b", rvalid, 4'b0000); end
      @(negedge clk);
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_rvalid_held: got %b expected %b", rvalid, 4'b0000); end
      resetn = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rstmid_regrant: got %b expected %b", gnt, 4'b0001); end
      go_idle();
   endtask

   // Watchdog so the run always ends even if the design stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence.
   initial begin
      test_reset();
      test_read_scan();
      test_contention();
      test_burst_limit();
      test_no_preempt();
      test_out_of_range();
      test_write_read();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
